soc_reset_sequencer: RTL and testbench

SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

---
 rtl/soc_reset_sequencer.sv | 128 ++++++++++++
 tb/tb_soc_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_sequencer.sv
// Power-on reset sequencer: PLL reset hold, lock wait, settle, then staggered peripheral/CPU release.
// Optional lock-wait timeout with PLL retry is enabled by defining RESET_SEQ_LOCK_TIMEOUT_EN.
module soc_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 32768,
    parameter int unsigned SETTLE_CYCLES  = 1048576,
    parameter int unsigned STAGGER_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic       periph_reset_n,
    output logic       cpu_reset_n,
    output logic       soc_ready,
    output logic [3:0] retry_count
);

    localparam int unsigned CNT_W   = 24;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned CNT_LIM = 1 << CNT_W;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    // Every duration must fit the shared 24-bit counter and be non-zero.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES >= CNT_LIM ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES >= CNT_LIM ||
        STAGGER_CYCLES < 1 || STAGGER_CYCLES >= CNT_LIM ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= CNT_LIM) begin : g_param_check
        $error("soc_reset_sequencer: cycle parameters must be in [1, 2^24)");
    end

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_PERIPH,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, lock_s_q;
    logic               pll_reset_d, periph_reset_n_d, cpu_reset_n_d, soc_ready_d;

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_RESET:     state_d = ST_HOLD;
            ST_HOLD:      if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_SETTLE;
                end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_HOLD;
                    if (retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + RETRY_W'(1);
                end
`endif
            end
            ST_SETTLE:    if (cnt_q == SETTLE_LAST) state_d = ST_PERIPH;
            ST_PERIPH:    if (cnt_q == STAGGER_LAST) state_d = ST_RUN;
            ST_RUN:       cnt_d = cnt_q;
            default:      state_d = ST_RESET;
        endcase
        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so the registered pins track the state exactly.
        pll_reset_d      = (state_d == ST_RESET) || (state_d == ST_HOLD);
        periph_reset_n_d = (state_d == ST_PERIPH) || (state_d == ST_RUN);
        cpu_reset_n_d    = (state_d == ST_RUN);
        soc_ready_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q        <= ST_RESET;
            cnt_q          <= '0;
            pll_reset      <= 1'b1;
            periph_reset_n <= 1'b0;
            cpu_reset_n    <= 1'b0;
            soc_ready      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pll_reset      <= pll_reset_d;
            periph_reset_n <= periph_reset_n_d;
            cpu_reset_n    <= cpu_reset_n_d;
            soc_ready      <= soc_ready_d;
        end
    end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_48mhz) begin
        if (reset) retry_q <= '0;
        else       retry_q <= retry_d;
    end

    assign retry_count = retry_q;
`else
    assign retry_count = '0;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Randomized scoreboard bench for soc_reset_sequencer against a deadline-based phase model.
module tb_soc_reset_sequencer;

    localparam int unsigned HOLD    = 16;
    localparam int unsigned SETTLE  = 8;
    localparam int unsigned STAGGER = 4;
    localparam int unsigned TIMEOUT = 32;

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int P_RESET  = 10;
    localparam int P_HOLD   = 11;
    localparam int P_WAIT   = 12;
    localparam int P_SETTLE = 13;
    localparam int P_PERIPH = 14;
    localparam int P_RUN    = 15;

    typedef struct packed {
        logic       pll_reset;
        logic       periph_reset_n;
        logic       cpu_reset_n;
        logic       soc_ready;
        logic [3:0] retry_count;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_reset, periph_reset_n, cpu_reset_n, soc_ready;
    logic [3:0] retry_count;

    always #5 clk = ~clk;

    soc_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .STAGGER_CYCLES(STAGGER),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_48mhz     (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .pll_reset     (pll_reset),
        .periph_reset_n(periph_reset_n),
        .cpu_reset_n   (cpu_reset_n),
        .soc_ready     (soc_ready),
        .retry_count   (retry_count)
    );

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_no = 0;

    // Reference model: a phase plus the absolute clock edge at which it ends.
    int m_phase = P_RESET;
    int m_deadline = 0;
    int m_retry = 0;
    bit m_lk1 = 1'b0;
    bit m_lk2 = 1'b0;

    function void model_step(input bit r, input bit p);
        bit lk;
        lk = m_lk2;
        if (r) begin
            m_phase = P_RESET;
            m_lk1   = 1'b0;
            m_lk2   = 1'b0;
            m_retry = 0;
            return;
        end
        m_lk2 = m_lk1;
        m_lk1 = p;
        case (m_phase)
            P_RESET: begin
                m_phase = P_HOLD;
                m_deadline = edge_no + HOLD;
            end
            P_HOLD: if (edge_no == m_deadline) begin
                m_phase = P_WAIT;
                m_deadline = edge_no + TIMEOUT;
            end
            P_WAIT: begin
                if (lk) begin
                    m_phase = P_SETTLE;
                    m_deadline = edge_no + SETTLE;
                end else if (TMO_EN && edge_no == m_deadline) begin
                    m_phase = P_HOLD;
                    m_deadline = edge_no + HOLD;
                    if (m_retry < 15) m_retry++;
                end
            end
            P_SETTLE: if (edge_no == m_deadline) begin
                m_phase = P_PERIPH;
                m_deadline = edge_no + STAGGER;
            end
            P_PERIPH: if (edge_no == m_deadline) m_phase = P_RUN;
            default: ;
        endcase
    endfunction

    function obs_t model_out();
        obs_t o;
        o.pll_reset      = (m_phase == P_RESET) || (m_phase == P_HOLD);
        o.periph_reset_n = (m_phase == P_PERIPH) || (m_phase == P_RUN);
        o.cpu_reset_n    = (m_phase == P_RUN);
        o.soc_ready      = (m_phase == P_RUN);
        o.retry_count    = 4'(m_retry);
        return o;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit r, input bit p);
        reset = r;
        pll_locked = p;
        @(posedge clk);
        edge_no++;
        model_step(r, p);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run_until(input int ph, input bit p, input int budget, input string name);
        int left;
        left = budget;
        while (m_phase != ph && left > 0) begin
            cyc(1'b0, p);
            left--;
        end
        if (m_phase != ph) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: phase %0d not reached within %0d cycles, required %0d", name, m_phase, budget, ph);
        end
    endtask

    // Monitor: compares the DUT's registered outputs against the oldest expectation.
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_reset, periph_reset_n, cpu_reset_n, soc_ready, retry_count};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs edge %0d: got pll_reset=%b periph_n=%b cpu_n=%b ready=%b retry=%0d, required pll_reset=%b periph_n=%b cpu_n=%b ready=%b retry=%0d",
                         edge_no, a.pll_reset, a.periph_reset_n, a.cpu_reset_n, a.soc_ready, a.retry_count,
                         e.pll_reset, e.periph_reset_n, e.cpu_reset_n, e.soc_ready, e.retry_count);
            end
        end
    end

    initial begin
        int lock_at, extra;
        bit p;

        // Nominal: 3 reset cycles, lock from around cycle 30.
        repeat (3) cyc(1'b1, 1'b0);
        lock_at = $urandom_range(25, 40);
        for (int i = 0; i < lock_at; i++) cyc(1'b0, 1'b0);
        run_until(P_RUN, 1'b1, 200, "nominal");
        repeat (10) cyc(1'b0, 1'b1);

        // Lock loss in RUN must be ignored.
        repeat (100) cyc(1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1);

        // Reset pulse during SETTLE, then full re-sequence.
        cyc(1'b1, 1'b1);
        run_until(P_SETTLE, 1'b1, 200, "reach_settle");
        extra = $urandom_range(0, 6);
        for (int i = 0; i < extra; i++) cyc(1'b0, 1'b1);
        extra = $urandom_range(1, 2);
        for (int i = 0; i < extra; i++) cyc(1'b1, 1'b1);
        run_until(P_RUN, 1'b1, 200, "resequence");
        repeat (5) cyc(1'b0, 1'b1);

        // Lock pulses for 3 cycles only, during WAIT_LOCK.
        repeat (2) cyc(1'b1, 1'b0);
        run_until(P_WAIT, 1'b0, 100, "reach_wait");
        extra = $urandom_range(0, 5);
        for (int i = 0; i < extra; i++) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        run_until(P_RUN, 1'b0, 100, "pulsed_lock");
        repeat (10) cyc(1'b0, 1'b0);

        // Lock held low for 1000 cycles: stuck in WAIT_LOCK or retrying, depending on build.
        repeat (2) cyc(1'b1, 1'b0);
        repeat (1000) cyc(1'b0, 1'b0);

        // Random reset and lock activity.
        p = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) p = ~p;
            cyc($urandom_range(0, 199) == 0, p);
        end

        repeat (5) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
